fifo_rd_stream: RTL and testbench

//  Read-side consumer for the async FIFO: drains the FIFO read port (pop/empty/data) and
//  re-presents the words as a registered valid/ready stream in the read clock domain.
//  It contains a 2-entry prefetch/skid buffer, so o_rinc never depends combinationally on i_ready.
//  It also keeps a wrapping count of delivered words for bench scoreboarding and status.
//  It sits between the FIFO read port and any read-domain sink.

---
 rtl/fifo_rd_stream.sv | 95 +++++++++
 tb/tb_fifo_rd_stream.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side FIFO consumer: pops an FWFT FIFO into a 2-entry prefetch buffer and
// presents the words as a registered valid/ready stream with a delivered-word counter.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_rclk,
    input  logic                  i_rrst_n,
    output logic                  o_rinc,
    input  logic                  i_rempty,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  i_enable,
    input  logic                  i_flush,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ready,
    output logic [1:0]            o_level,
    input  logic                  i_cnt_clr,
    output logic [CNT_WIDTH-1:0]  o_word_cnt
);

    logic [DATA_WIDTH-1:0] buf_q [2];
    logic                  wptr_q, wptr_d;
    logic                  rptr_q, rptr_d;
    logic [1:0]            level_q, level_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  pop;
    logic                  hs;

    // Pop depends only on registered level and FIFO/control inputs, never on i_ready.
    assign pop = i_rrst_n && !i_rempty && i_enable && !i_flush && (level_q < 2'd2);
    assign hs  = o_valid && i_ready;

    assign o_rinc     = pop;
    assign o_valid    = (level_q != 2'd0);
    assign o_data     = buf_q[rptr_q];
    assign o_level    = level_q;
    assign o_word_cnt = cnt_q;

    always_comb begin
        level_d = level_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (i_flush) begin
            level_d = 2'd0;
            wptr_d  = 1'b0;
            rptr_d  = 1'b0;
        end else begin
            wptr_d = wptr_q ^ pop;
            rptr_d = rptr_q ^ hs;
            case ({pop, hs})
                2'b10:   level_d = level_q + 2'd1;
                2'b01:   level_d = level_q - 2'd1;
                default: level_d = level_q;
            endcase
        end
    end

    // A handshake in the flush cycle still counts; clear beats increment.
    always_comb begin
        cnt_d = cnt_q;
        if (i_cnt_clr) begin
            cnt_d = '0;
        end else if (hs) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_rclk or negedge i_rrst_n) begin
        if (!i_rrst_n) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            level_q <= 2'd0;
            cnt_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge i_rclk or negedge i_rrst_n) begin
                if (!i_rrst_n) begin
                    buf_q[gi] <= '0;
                end else if (pop && (wptr_q == gi[0])) begin
                    buf_q[gi] <= i_rdata;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: an array-based FWFT FIFO model feeds the DUT and
// outputs are checked on the falling edge against hand-computed values.
module tb_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rinc;
    logic       rempty;
    logic [7:0] rdata;
    logic       enable;
    logic       flush;
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic [1:0] level;
    logic       cnt_clr;
    logic [15:0] word_cnt;

    logic       s_rinc;
    logic       s_valid;
    logic [7:0] s_data;
    logic [1:0] s_level;
    logic [3:0] s_word_cnt;

    logic [7:0] fifo_mem [0:255];
    logic [7:0] head = 8'd0;
    logic [7:0] tail;

    logic [7:0] rx_mem [0:255];
    int         rx_cnt = 0;
    int         base;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .i_rclk(clk), .i_rrst_n(rst_n), .o_rinc(rinc), .i_rempty(rempty),
        .i_rdata(rdata), .i_enable(enable), .i_flush(flush), .o_valid(valid),
        .o_data(data), .i_ready(ready), .o_level(level), .i_cnt_clr(cnt_clr),
        .o_word_cnt(word_cnt)
    );

    fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_w4 (
        .i_rclk(clk), .i_rrst_n(rst_n), .o_rinc(s_rinc), .i_rempty(rempty),
        .i_rdata(rdata), .i_enable(enable), .i_flush(flush), .o_valid(s_valid),
        .o_data(s_data), .i_ready(ready), .o_level(s_level), .i_cnt_clr(cnt_clr),
        .o_word_cnt(s_word_cnt)
    );

    assign rempty = (head == tail);
    assign rdata  = fifo_mem[head];

    always @(posedge clk) begin
        if (rinc) head <= head + 8'd1;
        if (rst_n && valid && ready) begin
            rx_mem[rx_cnt[7:0]] <= data;
            rx_cnt <= rx_cnt + 1;
        end
    end

    task automatic push(input logic [7:0] v);
        fifo_mem[tail] = v;
        tail = tail + 8'd1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; flush = 1'b0; ready = 1'b1; cnt_clr = 1'b0;
        tail = 8'd0;
        for (int i = 1; i <= 16; i++) push(8'(i));

        // Reset with a non-empty FIFO
        repeat (2) @(negedge clk);
        check("rst_rinc", 32'(rinc), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_cnt", 32'(word_cnt), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        $display("reset: rinc=%0d valid=%0d level=%0d cnt=%0d", rinc, valid, level, word_cnt);

        // Streaming 0x01..0x10 with ready held high
        rst_n = 1'b1;
        #1;
        check("first_pop", 32'(rinc), 32'd1);
        check("first_valid", 32'(valid), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            check("stream_valid", 32'(valid), 32'd1);
            check("stream_data", 32'(data), 32'(i));
            $display("stream: data=%02h level=%0d", data, level);
        end
        @(negedge clk);
        check("stream_end_valid", 32'(valid), 32'd0);
        check("stream_cnt", 32'(word_cnt), 32'd16);

        // Backpressure with 4 words queued
        ready = 1'b0;
        base = rx_cnt;
        for (int i = 1; i <= 4; i++) push(8'(i));
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(valid), 32'd1);
            check("bp_data", 32'(data), 32'h01);
            if (i >= 2) begin
                check("bp_level", 32'(level), 32'd2);
                check("bp_rinc", 32'(rinc), 32'd0);
            end
            $display("backpressure: data=%02h level=%0d rinc=%0d", data, level, rinc);
        end
        ready = 1'b1;
        repeat (6) @(negedge clk);
        check("bp_count", 32'(rx_cnt - base), 32'd4);
        for (int k = 0; k < 4; k++) check("bp_order", 32'(rx_mem[8'(base + k)]), 32'(k + 1));
        check("bp_cnt", 32'(word_cnt), 32'd20);

        // Flush with two buffered words
        ready = 1'b0;
        push(8'hA0); push(8'hA1); push(8'hA2);
        repeat (3) @(negedge clk);
        check("fl_level_pre", 32'(level), 32'd2);
        check("fl_data_pre", 32'(data), 32'hA0);
        flush = 1'b1;
        #1;
        check("fl_rinc", 32'(rinc), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        check("fl_valid", 32'(valid), 32'd0);
        check("fl_level", 32'(level), 32'd0);
        ready = 1'b1;
        @(negedge clk);
        check("fl_next_valid", 32'(valid), 32'd1);
        check("fl_next_data", 32'(data), 32'hA2);
        $display("flush: next data=%02h", data);
        @(negedge clk);
        check("fl_cnt", 32'(word_cnt), 32'd21);

        // Enable low blocks pops
        enable = 1'b0;
        push(8'h5A);
        repeat (3) @(negedge clk);
        check("en_rinc", 32'(rinc), 32'd0);
        check("en_level", 32'(level), 32'd0);
        enable = 1'b1;
        #1;
        check("en_resume_rinc", 32'(rinc), 32'd1);
        @(negedge clk);
        check("en_data", 32'(data), 32'h5A);
        $display("enable: data=%02h", data);
        @(negedge clk);
        check("en_cnt", 32'(word_cnt), 32'd22);

        // Counter clear and 4-bit wrap
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        check("clr_cnt", 32'(word_cnt), 32'd0);
        check("clr_cnt_w4", 32'(s_word_cnt), 32'd0);
        for (int i = 0; i < 17; i++) push(8'(8'h60 + i));
        repeat (20) @(negedge clk);
        check("wrap_main", 32'(word_cnt), 32'd17);
        check("wrap_w4", 32'(s_word_cnt), 32'd1);
        $display("wrap: cnt16=%0d cnt4=%0d", word_cnt, s_word_cnt);
        ready = 1'b0;
        push(8'hC0);
        repeat (2) @(negedge clk);
        check("clr_hs_valid_pre", 32'(valid), 32'd1);
        ready = 1'b1;
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        check("clr_hs_cnt", 32'(word_cnt), 32'd0);
        check("clr_hs_cnt_w4", 32'(s_word_cnt), 32'd0);
        check("clr_hs_valid", 32'(valid), 32'd0);

        // Asynchronous reset with a full buffer
        ready = 1'b0;
        push(8'hB0); push(8'hB1); push(8'hB2);
        repeat (3) @(negedge clk);
        check("mr_level_pre", 32'(level), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("mr_valid", 32'(valid), 32'd0);
        check("mr_level", 32'(level), 32'd0);
        check("mr_rinc", 32'(rinc), 32'd0);
        check("mr_data", 32'(data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        #1;
        check("mr_rinc_after", 32'(rinc), 32'd1);
        @(negedge clk);
        check("mr_next_valid", 32'(valid), 32'd1);
        check("mr_next_data", 32'(data), 32'hB2);
        $display("reset mid-stream: next data=%02h", data);
        @(negedge clk);
        check("mr_cnt", 32'(word_cnt), 32'd1);
        check("mr_end_valid", 32'(valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
